// File: rtl/riscv_bp_gshare.sv
`default_nettype none
// ============================================================================
// Module   : riscv_bp_gshare
// Purpose  : Gshare branch-prediction table. Each fetched PC is hashed with
//            the global branch history into a table of 2-bit saturating
//            counters. The counter value is registered and handed to ID as
//            the prediction. Resolved conditional branches write back an
//            updated counter. The table has no reset. After every reset an
//            init sweep writes weakly-not-taken to every entry, and live
//            predictions start only once that sweep is finished.
// Ports    : clk, rstn         - clock, asynchronous active-low reset
//            if_pc_i, if_stall_i
//                              - lookup address and lookup hold
//            bu_bp_history_i   - global history (lookup and update index)
//            ex_pc_i, ex_stall_i
//                              - update address and EX stall (blocks writes)
//            bu_bp_update_i, bu_bp_btaken_i, bu_bp_predict_i
//                              - resolved-branch update request
//            bp_predict_o      - registered prediction (bit1 = taken)
//            bp_init_o         - high while the init sweep runs
// Revision : 1.0 - initial release
// ============================================================================
module riscv_bp_gshare #(
  parameter int XLEN           = 32,
  parameter int BP_GLOBAL_BITS = 2,
  parameter int BP_LOCAL_BITS  = 10,
  parameter int HAS_RVC        = 0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [XLEN-1:0]           if_pc_i,
  input  logic                      if_stall_i,
  input  logic [BP_GLOBAL_BITS-1:0] bu_bp_history_i,
  input  logic [XLEN-1:0]           ex_pc_i,
  input  logic                      ex_stall_i,
  input  logic                      bu_bp_update_i,
  input  logic                      bu_bp_btaken_i,
  input  logic [1:0]                bu_bp_predict_i,
  output logic [1:0]                bp_predict_o,
  output logic                      bp_init_o
);

  localparam int IDX   = BP_GLOBAL_BITS + BP_LOCAL_BITS;
  localparam int DEPTH = 1 << IDX;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q;
  logic [IDX-1:0]   sweep_q;
  logic [1:0]       predict_q;
  logic [1:0]       table_q [DEPTH];

  logic [BP_LOCAL_BITS-1:0] rd_pc_bits;
  logic [BP_LOCAL_BITS-1:0] wr_pc_bits;
  logic [IDX-1:0]           rd_idx;
  logic [IDX-1:0]           wr_idx;
  logic                     wr_en;
  logic [1:0]               wr_data;
  logic [1:0]               sat_cnt;
  logic                     unused_pc;

  // With compressed instructions, PCs are halfword aligned, so the index
  // starts one bit lower.
  generate
    if (HAS_RVC != 0) begin : g_rvc
      assign rd_pc_bits = if_pc_i[BP_LOCAL_BITS:1];
      assign wr_pc_bits = ex_pc_i[BP_LOCAL_BITS:1];
    end else begin : g_no_rvc
      assign rd_pc_bits = if_pc_i[BP_LOCAL_BITS+1:2];
      assign wr_pc_bits = ex_pc_i[BP_LOCAL_BITS+1:2];
    end
  endgenerate

  // Only a slice of each PC forms the index.
  assign unused_pc = ^{if_pc_i, ex_pc_i};

  // Build the update value from the counter that was originally predicted,
  // not from a table read. The update then needs no read port and is
  // unaffected by any training that happened after the prediction was made.
  always_comb begin
    sat_cnt = bu_bp_predict_i;
    if (bu_bp_btaken_i) begin
      if (bu_bp_predict_i != 2'b11) sat_cnt = bu_bp_predict_i + 2'd1;
    end else begin
      if (bu_bp_predict_i != 2'b00) sat_cnt = bu_bp_predict_i - 2'd1;
    end
  end

  // While the sweep runs, it owns the single write port.
  always_comb begin
    rd_idx  = {bu_bp_history_i, rd_pc_bits};
    wr_idx  = {bu_bp_history_i, wr_pc_bits};
    wr_en   = bu_bp_update_i & ~ex_stall_i;
    wr_data = sat_cnt;
    if (state_q == ST_INIT) begin
      wr_idx  = sweep_q;
      wr_en   = 1'b1;
      wr_data = 2'b01;
    end
  end

  // Table storage has no reset; the sweep provides its known state.
  always_ff @(posedge clk) begin
    if (wr_en) table_q[wr_idx] <= wr_data;
  end

  // Control FSM plus registered lookup
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_INIT;
      sweep_q   <= '0;
      predict_q <= 2'b00;
    end else begin
      case (state_q)
        ST_INIT: begin
          predict_q <= 2'b00;
          sweep_q   <= sweep_q + IDX'(1);
          if (sweep_q == {IDX{1'b1}}) state_q <= ST_RUN;
        end
        default: begin
          // When a write hits the index being looked up in the same cycle,
          // the written value is forwarded to the lookup (write-first).
          if (!if_stall_i) begin
            if (wr_en && (wr_idx == rd_idx)) predict_q <= wr_data;
            else                              predict_q <= table_q[rd_idx];
          end
        end
      endcase
    end
  end

  assign bp_predict_o = predict_q;
  assign bp_init_o    = (state_q == ST_INIT);

endmodule
`default_nettype wire

// File: tb/tb_riscv_bp_gshare.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_bp_gshare
// Purpose  : Self-checking bench for riscv_bp_gshare (default parameters,
//            4096 entries). Uses a directed vector table plus hand-written
//            sequences for init, EX stall and mid-run reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_bp_gshare;

  logic        clk;
  logic        rstn;
  logic [31:0] if_pc;
  logic        if_stall;
  logic [1:0]  hist;
  logic [31:0] ex_pc;
  logic        ex_stall;
  logic        upd;
  logic        btaken;
  logic [1:0]  pred;
  logic [1:0]  bp_predict;
  logic        bp_init;

  int n_checks = 0;
  int n_pass   = 0;

  riscv_bp_gshare dut (
    .clk             (clk),
    .rstn            (rstn),
    .if_pc_i         (if_pc),
    .if_stall_i      (if_stall),
    .bu_bp_history_i (hist),
    .ex_pc_i         (ex_pc),
    .ex_stall_i      (ex_stall),
    .bu_bp_update_i  (upd),
    .bu_bp_btaken_i  (btaken),
    .bu_bp_predict_i (pred),
    .bp_predict_o    (bp_predict),
    .bp_init_o       (bp_init)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] if_pc;
    logic [1:0]  hist;
    logic        if_stall;
    logic        upd;
    logic [31:0] ex_pc;
    logic        ex_stall;
    logic        btaken;
    logic [1:0]  pred;
    logic [1:0]  exp_pred;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vec [NVEC];

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, want);
  endtask

  // Counts cycles from reset release until bp_init drops, bounded.
  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (n < 5000) begin
      @(posedge clk); #1;
      n++;
      if (!bp_init) break;
    end
    check(name, n, 4096);
  endtask

  // Apply one set of inputs for a single cycle and check the result 1ns
  // after the active edge.
  task automatic step(input vec_t v, input string name);
    @(negedge clk);
    if_pc    = v.if_pc;
    hist     = v.hist;
    if_stall = v.if_stall;
    upd      = v.upd;
    ex_pc    = v.ex_pc;
    ex_stall = v.ex_stall;
    btaken   = v.btaken;
    pred     = v.pred;
    @(posedge clk); #1;
    check(name, int'(bp_predict), int'(v.exp_pred));
  endtask

  initial begin
    int bad_init;
    vec_t s;

    //          if_pc        h     ifs   upd   ex_pc        exs   tk    pred   exp
    vec[0]  = '{32'h0000_0200, 2'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0, 2'b01};
    vec[1]  = '{32'h0000_1FFC, 2'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0, 2'b01};
    vec[2]  = '{32'h0000_FFF0, 2'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0, 2'b01};
    vec[3]  = '{32'h0000_0300, 2'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0, 2'b01};
    // train 0x200 taken: 01->10, 10->11, 11->11
    vec[4]  = '{32'h0000_1FFC, 2'd0, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b1, 2'd1, 2'b01};
    vec[5]  = '{32'h0000_FFF0, 2'd0, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b1, 2'd2, 2'b01};
    vec[6]  = '{32'h0000_1FFC, 2'd0, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b1, 2'd3, 2'b01};
    vec[7]  = '{32'h0000_0200, 2'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0, 2'b11};
    vec[8]  = '{32'h0000_0200, 2'd1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0, 2'b01};
    // not-taken saturation at 0x400
    vec[9]  = '{32'h0000_0200, 2'd0, 1'b0, 1'b1, 32'h0000_0400, 1'b0, 1'b0, 2'd1, 2'b11};
    vec[10] = '{32'h0000_0404, 2'd0, 1'b0, 1'b1, 32'h0000_0400, 1'b0, 1'b0, 2'd0, 2'b01};
    vec[11] = '{32'h0000_0400, 2'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0, 2'b00};
    // same-edge collision, then a different-index lookup
    vec[12] = '{32'h0000_0500, 2'd0, 1'b0, 1'b1, 32'h0000_0500, 1'b0, 1'b1, 2'd1, 2'b10};
    vec[13] = '{32'h0000_0500, 2'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0, 2'b10};
    vec[14] = '{32'h0000_0604, 2'd0, 1'b0, 1'b1, 32'h0000_0600, 1'b0, 1'b1, 2'd1, 2'b01};
    vec[15] = '{32'h0000_0600, 2'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0, 2'b10};
    // if_stall holds the previous prediction
    vec[16] = '{32'h0000_0400, 2'd0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0, 2'b10};
    vec[17] = '{32'h0000_0400, 2'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0, 2'b00};
    // not-taken from 11 with collision forwarding: 10
    vec[18] = '{32'h0000_0700, 2'd0, 1'b0, 1'b1, 32'h0000_0700, 1'b0, 1'b0, 2'd3, 2'b10};

    rstn = 1'b1; if_pc = '0; if_stall = 1'b0; hist = '0; ex_pc = '0;
    ex_stall = 1'b0; upd = 1'b0; btaken = 1'b0; pred = '0;
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_predict", int'(bp_predict), 0);
    check("reset_init", int'(bp_init), 1);

    // Hold an update for 0x300 (would write 11) during the whole sweep.
    @(negedge clk);
    ex_pc = 32'h0000_0300; upd = 1'b1; btaken = 1'b1; pred = 2'd2;
    if_pc = 32'h0000_0300;
    rstn = 1'b1;
    bad_init = 0;
    begin
      int n;
      n = 0;
      while (n < 5000) begin
        @(posedge clk); #1;
        n++;
        if (!bp_init) break;
        if (bp_predict != 2'b00) bad_init++;
      end
      check("init_cycles", n, 4096);
    end
    check("init_predict_zero", bad_init, 0);
    upd = 1'b0;

    for (int i = 0; i < NVEC; i++) step(vec[i], $sformatf("vec%0d", i));

    // ex_stall for 3 cycles with update held: no write, then exactly one
    s = '{32'h0000_0800, 2'd0, 1'b0, 1'b1, 32'h0000_0800, 1'b1, 1'b1, 2'd1, 2'b01};
    for (int k = 0; k < 3; k++) step(s, $sformatf("stall%0d", k));
    s.ex_stall = 1'b0; s.exp_pred = 2'b10;
    step(s, "stall_release");
    s.upd = 1'b0;
    step(s, "stall_single_write");

    // Mid-run reset: entry 0x200 is trained to 11
    s = '{32'h0000_0200, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 2'b11};
    step(s, "pre_reset_lookup");
    #2 rstn = 1'b0;
    #1;
    check("async_reset_predict", int'(bp_predict), 0);
    check("async_reset_init", int'(bp_init), 1);
    @(negedge clk);
    rstn = 1'b1;
    wait_init("reinit_cycles");
    s.exp_pred = 2'b01;
    step(s, "post_reinit_0x200");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
